// File: rtl/ysyx_23060096_imm_stage_if.sv
// Handshake bundle for ysyx_23060096_imm_stage: input beat, output FIFO head and flush.
// out_target exists only when YSYX_23060096_IMM_TARGET_EN is defined.
interface ysyx_23060096_imm_stage_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic [2:0]      in_extop;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;
`ifdef YSYX_23060096_IMM_TARGET_EN
  logic [XLEN-1:0] out_target;

  modport master (
    output flush, in_valid, in_inst, in_pc, in_extop, out_ready,
    input  in_ready, out_valid, out_imm, out_illegal, out_target
  );

  modport slave (
    input  flush, in_valid, in_inst, in_pc, in_extop, out_ready,
    output in_ready, out_valid, out_imm, out_illegal, out_target
  );
`else
  modport master (
    output flush, in_valid, in_inst, in_pc, in_extop, out_ready,
    input  in_ready, out_valid, out_imm, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_inst, in_pc, in_extop, out_ready,
    output in_ready, out_valid, out_imm, out_illegal
  );
`endif
endinterface

// File: rtl/ysyx_23060096_imm_stage.sv
// Buffered RISC-V immediate generator with a 1- or 2-entry output FIFO.
// Optional branch/jump target (in_pc + imm) per entry under YSYX_23060096_IMM_TARGET_EN.
module ysyx_23060096_imm_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input logic                     clk,
  input logic                     rstn,
  ysyx_23060096_imm_stage_if.slave bus
);

  if (XLEN != 32 && XLEN != 64) begin : gBadXlen
    $error("ysyx_23060096_imm_stage: XLEN must be 32 or 64");
  end
  if (DEPTH != 1 && DEPTH != 2) begin : gBadDepth
    $error("ysyx_23060096_imm_stage: DEPTH must be 1 or 2");
  end

  localparam logic [0:0] lastIdx   = 1'(DEPTH - 1);
  localparam logic [1:0] depthCount = 2'(DEPTH);

  logic [1:0]      count;
  logic [0:0]      wrPtr;
  logic [0:0]      rdPtr;
  logic            outValid;
  logic            inReady;
  logic            push;
  logic            pop;

  logic [XLEN-1:0] immMem [DEPTH];
  logic            illMem [DEPTH];
  logic [XLEN-1:0] immNext;
  logic            illNext;

  logic signed [11:0] iField;
  logic signed [11:0] sField;
  logic signed [12:0] bField;
  logic signed [20:0] jField;
  logic signed [31:0] uField;

  assign iField = bus.in_inst[31:20];
  assign sField = {bus.in_inst[31:25], bus.in_inst[11:7]};
  assign bField = {bus.in_inst[31], bus.in_inst[7], bus.in_inst[30:25], bus.in_inst[11:8], 1'b0};
  assign jField = {bus.in_inst[31], bus.in_inst[19:12], bus.in_inst[20], bus.in_inst[30:21], 1'b0};
  assign uField = {bus.in_inst[31:12], 12'b0};

  // Sized casts of the signed fields sign-extend; Z and SH are unsigned and zero-extend.
  always_comb begin
    immNext = '0;
    illNext = 1'b0;
    case (bus.in_extop)
      3'b000:  immNext = XLEN'(iField);
      3'b001:  immNext = XLEN'(uField);
      3'b010:  immNext = XLEN'(sField);
      3'b011:  immNext = XLEN'(bField);
      3'b100:  immNext = XLEN'(jField);
      3'b101:  immNext = XLEN'(bus.in_inst[19:15]);
      3'b110:  immNext = (XLEN == 64) ? XLEN'(bus.in_inst[25:20]) : XLEN'(bus.in_inst[24:20]);
      default: begin
        immNext = '0;
        illNext = 1'b1;
      end
    endcase
  end

  assign outValid = (count != 2'd0);
  assign inReady  = (count < depthCount);
  assign push     = bus.in_valid && inReady && !bus.flush;
  assign pop      = outValid && bus.out_ready && !bus.flush;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= 2'd0;
      wrPtr <= 1'b0;
      rdPtr <= 1'b0;
    end else if (bus.flush) begin
      count <= 2'd0;
      wrPtr <= 1'b0;
      rdPtr <= 1'b0;
    end else begin
      if (push) wrPtr <= (wrPtr == lastIdx) ? 1'b0 : wrPtr + 1'b1;
      if (pop)  rdPtr <= (rdPtr == lastIdx) ? 1'b0 : rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload is don't-care while its slot is invalid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      immMem[wrPtr] <= immNext;
      illMem[wrPtr] <= illNext;
    end
  end

  assign bus.in_ready    = inReady;
  assign bus.out_valid   = outValid;
  assign bus.out_imm     = outValid ? immMem[rdPtr] : '0;
  assign bus.out_illegal = outValid ? illMem[rdPtr] : 1'b0;

`ifdef YSYX_23060096_IMM_TARGET_EN
  logic [XLEN-1:0] tgtMem [DEPTH];
  logic [XLEN-1:0] tgtNext;

  assign tgtNext = bus.in_pc + immNext;

  always_ff @(posedge clk) begin
    if (push) tgtMem[wrPtr] <= tgtNext;
  end

  assign bus.out_target = outValid ? tgtMem[rdPtr] : '0;
`else
  logic unusedPc;
  assign unusedPc = ^bus.in_pc;
`endif

  logic unusedOpcode;
  assign unusedOpcode = ^bus.in_inst[6:0];

endmodule

// File: tb/tb_ysyx_23060096_imm_stage.sv
// Directed self-checking bench for ysyx_23060096_imm_stage (RV32 and RV64 instances).
// Target checks are compiled in only when YSYX_23060096_IMM_TARGET_EN is defined.
module tb_ysyx_23060096_imm_stage;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  ysyx_23060096_imm_stage_if #(.XLEN(32)) b32 ();
  ysyx_23060096_imm_stage_if #(.XLEN(64)) b64 ();

  ysyx_23060096_imm_stage #(.XLEN(32), .DEPTH(2)) dut32 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (b32.slave)
  );

  ysyx_23060096_imm_stage #(.XLEN(64), .DEPTH(2)) dut64 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (b64.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic v, input logic [31:0] inst, input logic [2:0] op);
    b32.in_valid = v;
    b32.in_inst  = inst;
    b32.in_extop = op;
  endtask

  task automatic drive64(input logic v, input logic [31:0] inst, input logic [2:0] op);
    b64.in_valid = v;
    b64.in_inst  = inst;
    b64.in_extop = op;
  endtask

  function automatic logic [31:0] iInst(input int imm);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 20'h00013};
  endfunction

  task automatic test_reset();
    #3;
    checks++;
    if ({b32.out_valid, b32.in_ready, b32.out_illegal} !== 3'b010) begin
      failures++;
      $display("[TB] FAIL reset32_flags got=%b exp=010", {b32.out_valid, b32.in_ready, b32.out_illegal});
    end
    checks++;
    if (b32.out_imm !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset32_imm got=%h exp=0", b32.out_imm);
    end
    checks++;
    if ({b64.out_valid, b64.in_ready, b64.out_illegal} !== 3'b010) begin
      failures++;
      $display("[TB] FAIL reset64_flags got=%b exp=010", {b64.out_valid, b64.in_ready, b64.out_illegal});
    end
    checks++;
    if (b64.out_imm !== 64'h0) begin
      failures++;
      $display("[TB] FAIL reset64_imm got=%h exp=0", b64.out_imm);
    end
`ifdef YSYX_23060096_IMM_TARGET_EN
    checks++;
    if (b32.out_target !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset32_target got=%h exp=0", b32.out_target);
    end
`endif
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_rv32();
    b32.out_ready = 1'b1;
    drive32(1'b1, 32'hFFF00093, 3'b000);
    checks++;
    if (b32.out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rv32_no_comb_path got=%b exp=0", b32.out_valid);
    end
    tick();
    drive32(1'b1, 32'h123450B7, 3'b001);
    checks++;
    if ({b32.out_valid, b32.out_illegal, b32.out_imm} !== {2'b10, 32'hFFFFFFFF}) begin
      failures++;
      $display("[TB] FAIL rv32_i got=%b/%b/%h exp=1/0/ffffffff", b32.out_valid, b32.out_illegal, b32.out_imm);
    end
    tick();
    drive32(1'b1, 32'h03F01013, 3'b110);
    checks++;
    if (b32.out_imm !== 32'h12345000) begin
      failures++;
      $display("[TB] FAIL rv32_u got=%h exp=12345000", b32.out_imm);
    end
    tick();
    drive32(1'b0, 32'h0, 3'b000);
    checks++;
    if (b32.out_imm !== 32'h0000001F) begin
      failures++;
      $display("[TB] FAIL rv32_sh got=%h exp=0000001f", b32.out_imm);
    end
    tick();
    checks++;
    if (b32.out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rv32_drain got=%b exp=0", b32.out_valid);
    end
  endtask

  task automatic test_rv64();
    logic [31:0] insts [5] = '{32'hFFDFF06F, 32'h00000463, 32'h02A05073, 32'h03F01013, 32'h800000B7};
    logic [2:0]  ops   [5] = '{3'b100, 3'b011, 3'b101, 3'b110, 3'b001};
    logic [63:0] exps  [5] = '{64'hFFFFFFFFFFFFFFFC, 64'h8, 64'h0, 64'h3F, 64'hFFFFFFFF80000000};
    b64.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive64(1'b1, insts[i], ops[i]);
      tick();
      checks++;
      if ({b64.out_valid, b64.out_imm} !== {1'b1, exps[i]}) begin
        failures++;
        $display("[TB] FAIL rv64_beat%0d got=%b/%h exp=1/%h", i, b64.out_valid, b64.out_imm, exps[i]);
      end
    end
    drive64(1'b0, 32'h0, 3'b000);
    tick();
  endtask

  task automatic test_backpressure();
    int expv [3] = '{1, 2, 3};
    int g;
    logic acc;
    b32.out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      drive32(1'b1, iInst(k), 3'b000);
      checks++;
      if (b32.in_ready !== (k < 3)) begin
        failures++;
        $display("[TB] FAIL bp_in_ready%0d got=%b exp=%b", k, b32.in_ready, (k < 3));
      end
      if (k < 3) tick();
    end
    b32.out_ready = 1'b1;
    g = 0;
    for (int cyc = 0; cyc < 10 && g < 3; cyc++) begin
      if (b32.out_valid && b32.out_ready) begin
        checks++;
        if (b32.out_imm !== 32'(expv[g])) begin
          failures++;
          $display("[TB] FAIL bp_order%0d got=%h exp=%h", g, b32.out_imm, 32'(expv[g]));
        end
        g++;
      end
      if (g < 3) begin
        acc = b32.in_valid && b32.in_ready;
        tick();
        if (acc) drive32(1'b0, 32'h0, 3'b000);
      end
    end
    checks++;
    if (g != 3) begin
      failures++;
      $display("[TB] FAIL bp_timeout got=%0d exp=3", g);
    end
    drive32(1'b0, 32'h0, 3'b000);
    tick();
    checks++;
    if (b32.out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_no_dup got=%b exp=0", b32.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    b32.out_ready = 1'b0;
    drive32(1'b1, iInst(100), 3'b000);
    tick();
    b32.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive32(1'b1, iInst(101 + i), 3'b000);
      checks++;
      if ({b32.out_valid, b32.in_ready, b32.out_imm} !== {2'b11, 32'(100 + i)}) begin
        failures++;
        $display("[TB] FAIL b2b_cycle%0d got=%b/%b/%h exp=1/1/%h",
                 i, b32.out_valid, b32.in_ready, b32.out_imm, 32'(100 + i));
      end
      tick();
    end
    drive32(1'b0, 32'h0, 3'b000);
    checks++;
    if (b32.out_imm !== 32'd110) begin
      failures++;
      $display("[TB] FAIL b2b_last got=%h exp=%h", b32.out_imm, 32'd110);
    end
    tick();
    checks++;
    if (b32.out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_empty got=%b exp=0", b32.out_valid);
    end
  endtask

  task automatic test_flush();
    b32.out_ready = 1'b0;
    drive32(1'b1, iInst(7), 3'b000);
    tick();
    drive32(1'b1, iInst(8), 3'b000);
    tick();
    b32.flush     = 1'b1;
    b32.out_ready = 1'b1;
    drive32(1'b1, iInst(9), 3'b000);
    tick();
    b32.flush = 1'b0;
    drive32(1'b0, 32'h0, 3'b000);
    checks++;
    if ({b32.out_valid, b32.in_ready, b32.out_imm} !== {2'b01, 32'h0}) begin
      failures++;
      $display("[TB] FAIL flush_full got=%b/%b/%h exp=0/1/0", b32.out_valid, b32.in_ready, b32.out_imm);
    end
    tick();
    checks++;
    if (b32.out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_stays_empty got=%b exp=0", b32.out_valid);
    end
    drive32(1'b1, iInst(10), 3'b000);
    tick();
    drive32(1'b0, 32'h0, 3'b000);
    checks++;
    if ({b32.out_valid, b32.out_imm} !== {1'b1, 32'd10}) begin
      failures++;
      $display("[TB] FAIL flush_refill got=%b/%h exp=1/%h", b32.out_valid, b32.out_imm, 32'd10);
    end
    b32.out_ready = 1'b0;
    tick();
    b32.flush = 1'b1;
    drive32(1'b1, iInst(12), 3'b000);
    tick();
    b32.flush = 1'b0;
    drive32(1'b0, 32'h0, 3'b000);
    checks++;
    if (b32.out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_drops_input got=%b exp=0", b32.out_valid);
    end
  endtask

  task automatic test_illegal();
    b32.out_ready = 1'b1;
    drive32(1'b1, 32'hFFFFFFFF, 3'b111);
    tick();
    drive32(1'b0, 32'h0, 3'b000);
    checks++;
    if ({b32.out_valid, b32.out_illegal, b32.out_imm} !== {2'b11, 32'h0}) begin
      failures++;
      $display("[TB] FAIL illegal got=%b/%b/%h exp=1/1/0", b32.out_valid, b32.out_illegal, b32.out_imm);
    end
    tick();
    checks++;
    if ({b32.out_valid, b32.out_illegal} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL illegal_cleared got=%b exp=00", {b32.out_valid, b32.out_illegal});
    end
  endtask

  task automatic test_reset_mid();
    b32.out_ready = 1'b0;
    drive32(1'b1, iInst(5), 3'b000);
    tick();
    drive32(1'b1, 32'h0, 3'b111);
    tick();
    drive32(1'b0, 32'h0, 3'b000);
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({b32.out_valid, b32.in_ready, b32.out_illegal, b32.out_imm} !== {3'b010, 32'h0}) begin
      failures++;
      $display("[TB] FAIL reset_mid got=%b/%b/%b/%h exp=0/1/0/0",
               b32.out_valid, b32.in_ready, b32.out_illegal, b32.out_imm);
    end
`ifdef YSYX_23060096_IMM_TARGET_EN
    checks++;
    if (b32.out_target !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_mid_target got=%h exp=0", b32.out_target);
    end
`endif
    @(negedge clk);
    rstn = 1'b1;
    tick();
    checks++;
    if (b32.out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_needs_push got=%b exp=0", b32.out_valid);
    end
  endtask

`ifdef YSYX_23060096_IMM_TARGET_EN
  task automatic test_target();
    b32.out_ready = 1'b1;
    b32.in_pc     = 32'h80000000;
    drive32(1'b1, 32'hFFDFF06F, 3'b100);
    tick();
    b32.in_pc = 32'h00000002;
    checks++;
    if ({b32.out_target, b32.out_imm} !== {32'h7FFFFFFC, 32'hFFFFFFFC}) begin
      failures++;
      $display("[TB] FAIL target got=%h/%h exp=7ffffffc/fffffffc", b32.out_target, b32.out_imm);
    end
    tick();
    drive32(1'b0, 32'h0, 3'b000);
    checks++;
    if (b32.out_target !== 32'hFFFFFFFE) begin
      failures++;
      $display("[TB] FAIL target_wrap got=%h exp=fffffffe", b32.out_target);
    end
    tick();
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    rstn     = 1'b0;
    b32.flush = 1'b0; b32.out_ready = 1'b0; b32.in_pc = '0;
    b64.flush = 1'b0; b64.out_ready = 1'b0; b64.in_pc = '0;
    drive32(1'b0, 32'h0, 3'b000);
    drive64(1'b0, 32'h0, 3'b000);
    test_reset();
    test_rv32();
    test_rv64();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_reset_mid();
`ifdef YSYX_23060096_IMM_TARGET_EN
    test_target();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
